if_fetch_unit: RTL and testbench

//   Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register.

---
 rtl/if_fetch_unit.sv | 112 +++++++++++
 tb/tb_if_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory, next-PC selection
// and an IDLE/RUN/HALT run-control FSM that gates fetch and allows program loading while idle.
module if_fetch_unit #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter string       INIT_FILE = ""
) (
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [31:0]       BranchTarget,
  input  logic              Jump,
  input  logic [31:0]       JumpTarget,
  input  logic              ImemWrEn,
  input  logic [ADDR_W-1:0] ImemWrAddr,
  input  logic [31:0]       ImemWrData,
  output logic [31:0]       Out_PC,
  output logic [31:0]       Out_PCPlus4,
  output logic [31:0]       Out_Instruction,
  output logic              Out_Valid,
  output logic              Flush,
  output logic              Halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_INIT   = RESET_PC & WORD_MASK;

  logic [31:0] mem [DEPTH];

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        running;
  logic        mem_wr;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  assign running  = (state == RUN);
  assign pc_plus4 = pc + 32'd4;
  assign instr    = mem[pc[ADDR_W+1:2]];
  assign mem_wr   = ImemWrEn & ~running;

  always_ff @(posedge ClockIn) begin
    if (mem_wr) begin
      mem[ImemWrAddr] <= ImemWrData;
    end
  end

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      pc    <= PC_INIT;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Stall outranks any redirect; a redirect outranks the halt so a HALT in a shadow is skipped.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = PC_INIT;
        end
      end
      RUN: begin
        if (Stall) begin
          pc_next = pc;
        end else if (BranchTaken) begin
          pc_next = BranchTarget & WORD_MASK;
        end else if (Jump) begin
          pc_next = JumpTarget & WORD_MASK;
        end else if (instr == HALT_WORD) begin
          state_next = HALT;
        end else begin
          pc_next = pc_plus4;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = PC_INIT;
      end
    endcase
  end

  assign Out_PC          = pc;
  assign Out_PCPlus4     = pc_plus4;
  assign Out_Valid       = running;
  assign Out_Instruction = running ? instr : '0;
  assign Flush           = running & ~Stall & (BranchTaken | Jump);
  assign Halted          = (state == HALT);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a table of per-cycle stimulus/expected records plus
// hand-written sequences for reset behaviour.
module tb_if_fetch_unit;

    localparam logic [31:0] ADDI = 32'h2084_0001;
    localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
    localparam logic [31:0] W08  = 32'hAAAA_0008;
    localparam logic [31:0] W0C  = 32'hBBBB_000C;
    localparam logic [31:0] WFF  = 32'hCCCC_00FF;
    localparam logic [31:0] W02  = 32'h5555_0002;
    localparam int unsigned NVEC = 23;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, bt, jmp, wen;
    logic [31:0] btgt, jtgt, wdata;
    logic [7:0]  waddr;
    logic [31:0] out_pc, out_pc4, out_instr;
    logic        out_valid, flush, halted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        start, stall, bt, jmp, wen;
        logic [31:0] btgt, jtgt, wdata;
        logic [7:0]  waddr;
        logic [31:0] pc, instr;
        logic        valid, flush, halted;
    } vec_t;

    vec_t tbl [NVEC];

    if_fetch_unit #(
        .ADDR_W   (8),
        .RESET_PC (32'h0000_0000),
        .HALT_WORD(32'hFFFF_FFFF),
        .INIT_FILE("")
    ) dut (
        .ClockIn        (clk),
        .Reset          (rst_n),
        .Start          (start),
        .Stall          (stall),
        .BranchTaken    (bt),
        .BranchTarget   (btgt),
        .Jump           (jmp),
        .JumpTarget     (jtgt),
        .ImemWrEn       (wen),
        .ImemWrAddr     (waddr),
        .ImemWrData     (wdata),
        .Out_PC         (out_pc),
        .Out_PCPlus4    (out_pc4),
        .Out_Instruction(out_instr),
        .Out_Valid      (out_valid),
        .Flush          (flush),
        .Halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic st, input logic b, input logic [31:0] bta,
                                input logic j, input logic [31:0] jta, input logic we,
                                input logic [7:0] wa, input logic [31:0] wd, input logic [31:0] epc,
                                input logic ev, input logic [31:0] ei, input logic ef, input logic eh);
        vec_t v;
        v.start = s;  v.stall = st; v.bt = b;   v.btgt = bta; v.jmp = j;  v.jtgt = jta;
        v.wen = we;   v.waddr = wa; v.wdata = wd;
        v.pc = epc;   v.valid = ev; v.instr = ei; v.flush = ef; v.halted = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input logic ev,
                           input logic [31:0] ei, input logic ef, input logic eh);
        chk({tag, " pc"},    out_pc,           epc);
        chk({tag, " pc4"},   out_pc4,          epc + 32'd4);
        chk({tag, " valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, " instr"}, out_instr,        ei);
        chk({tag, " flush"}, {31'd0, flush},   {31'd0, ef});
        chk({tag, " halt"},  {31'd0, halted},  {31'd0, eh});
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; bt = 0; jmp = 0; wen = 0;
        btgt = '0; jtgt = '0; waddr = '0; wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        wen = 1; waddr = a; wdata = d;
        step();
        wen = 0;
    endtask

    initial begin
        // x1: start, stall, bt, btgt, jmp, jtgt, wen, waddr, wdata | pc, valid, instr, flush, halted
        tbl[0]  = mk(1,0,0,0,     0,0,     0,0,0,        32'h000,0,0,   0,0);
        tbl[1]  = mk(0,0,0,0,     0,0,     0,0,0,        32'h000,1,ADDI,0,0);
        tbl[2]  = mk(0,0,0,0,     0,0,     0,0,0,        32'h004,1,ADDI,0,0);
        tbl[3]  = mk(0,0,0,0,     0,0,     0,0,0,        32'h008,1,ADDI,0,0);
        tbl[4]  = mk(0,0,0,0,     0,0,     0,0,0,        32'h00C,1,ADDI,0,0);
        tbl[5]  = mk(0,0,0,0,     0,0,     0,0,0,        32'h010,1,HLT, 0,0);
        tbl[6]  = mk(0,0,0,0,     0,0,     0,0,0,        32'h010,0,0,   0,1);
        tbl[7]  = mk(0,0,0,0,     0,0,     1,1,HLT,      32'h010,0,0,   0,1);
        tbl[8]  = mk(1,0,0,0,     0,0,     1,2,W02,      32'h010,0,0,   0,1);
        tbl[9]  = mk(0,0,0,0,     0,0,     1,2,32'hDEADBEEF,32'h000,1,ADDI,0,0);
        tbl[10] = mk(0,0,1,32'h0B,0,0,     0,0,0,        32'h004,1,HLT, 1,0);
        tbl[11] = mk(0,0,1,32'h23,1,32'h30,0,0,0,        32'h008,1,W02, 1,0);
        tbl[12] = mk(0,0,0,0,     1,32'h0E,0,0,0,        32'h020,1,W08, 1,0);
        tbl[13] = mk(0,1,1,32'h30,0,0,     0,0,0,        32'h00C,1,ADDI,0,0);
        tbl[14] = mk(0,1,1,32'h30,0,0,     0,0,0,        32'h00C,1,ADDI,0,0);
        tbl[15] = mk(0,0,1,32'h30,0,0,     0,0,0,        32'h00C,1,ADDI,1,0);
        tbl[16] = mk(0,0,0,0,     1,32'h3FF,0,0,0,       32'h030,1,W0C, 1,0);
        tbl[17] = mk(0,0,0,0,     0,0,     0,0,0,        32'h3FC,1,WFF, 0,0);
        tbl[18] = mk(0,0,0,0,     0,0,     0,0,0,        32'h400,1,ADDI,0,0);
        tbl[19] = mk(0,0,0,0,     0,0,     0,0,0,        32'h404,1,HLT, 0,0);
        tbl[20] = mk(0,0,0,0,     0,0,     0,0,0,        32'h404,0,0,   0,1);
        tbl[21] = mk(1,0,0,0,     0,0,     0,0,0,        32'h404,0,0,   0,1);
        tbl[22] = mk(0,0,0,0,     1,32'h40,0,0,0,        32'h000,1,ADDI,1,0);

        idle_inputs();
        rst_n = 0;
        #2;
        chk_all("reset", 32'h0, 0, 32'h0, 0, 0);
        step();
        rst_n = 1;
        step();
        chk_all("idle", 32'h0, 0, 32'h0, 0, 0);

        for (int unsigned a = 0; a < 4; a++) load(a[7:0], ADDI);
        load(8'd4,   HLT);
        load(8'd8,   W08);
        load(8'd12,  W0C);
        load(8'd255, WFF);

        for (int unsigned i = 0; i < NVEC; i++) begin
            start = tbl[i].start; stall = tbl[i].stall; bt = tbl[i].bt; btgt = tbl[i].btgt;
            jmp = tbl[i].jmp; jtgt = tbl[i].jtgt; wen = tbl[i].wen; waddr = tbl[i].waddr;
            wdata = tbl[i].wdata;
            #1;
            chk_all($sformatf("v%0d", i), tbl[i].pc, tbl[i].valid, tbl[i].instr,
                    tbl[i].flush, tbl[i].halted);
            step();
        end
        idle_inputs();

        // Unloaded word at 0x40 reads as zero but is still a valid fetch.
        #1;
        chk_all("pc40", 32'h40, 1, 32'h0, 0, 0);

        // Asynchronous reset mid-cycle with a redirect pending.
        bt = 1; btgt = 32'h80;
        #1;
        chk("pre-rst flush", {31'd0, flush}, 32'd1);
        rst_n = 0;
        #1;
        chk_all("async rst", 32'h0, 0, 32'h0, 0, 0);
        step();
        idle_inputs();
        rst_n = 1;
        step();
        chk_all("post rst", 32'h0, 0, 32'h0, 0, 0);

        // Memory survives reset.
        start = 1;
        step();
        start = 0;
        #1;
        chk_all("mem kept", 32'h0, 1, ADDI, 0, 0);
        step();
        chk_all("mem kept w1", 32'h4, 1, HLT, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected end before 20000");
        $fatal(1);
    end

endmodule
